// File: rtl/frame_buffer_ram_pkg.sv
// Shared types and constants for the frame buffer RAM and its clear engine.
// State table for the clear sequencer in frame_buffer_ram:
//   state        | meaning
//   FB_ST_IDLE   | user writes accepted, waiting for clr_start
//   FB_ST_CLEAR  | sweeping the fill colour over every location, user writes blocked
package frame_buffer_ram_pkg;

  typedef enum logic {
    FB_ST_IDLE  = 1'b0,
    FB_ST_CLEAR = 1'b1
  } fb_state_t;

  // Active VGA geometry; a full frame of pixels sizes DEPTH in the real build.
  localparam int H_ACTIVE = 320;
  localparam int V_ACTIVE = 240;
  localparam int FB_DEPTH = H_ACTIVE * V_ACTIVE;

  // DEPTH need not be a power of two, so addresses must be range-checked.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/frame_buffer_ram_dp_ram_core.sv
// Plain simple-dual-port RAM, no reset so it maps onto block RAM.
// The read data is registered (rather than the address) so a read and a write
// to the same location on the same edge return the old contents.
module frame_buffer_ram_dp_ram_core #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_q;

  // Write port plus read-first synchronous read; r_q holds when no read is issued
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/frame_buffer_ram.sv
// Pixel frame buffer: simple-dual-port RAM with a built-in clear engine,
// read-valid tracking and an optional output register on the read path.
module frame_buffer_ram
  import frame_buffer_ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 3,
  parameter int DEPTH          = 2**ADDR_WIDTH,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  clr_start,
  input  logic [DATA_WIDTH-1:0] clr_value,
  output logic                  clr_busy,
  output logic                  clr_done
);

  fb_state_t             r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_fill;
  logic                  r_done;
  logic                  r_rd_v1;

  logic                  w_busy;
  logic                  w_last;
  logic                  w_user_wr;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rd_q;

  assign w_busy    = (r_state == FB_ST_CLEAR);
  assign w_last    = (32'(r_cnt) == 32'(DEPTH - 1));
  // Out-of-range user addresses are dropped instead of aliasing onto real pixels.
  assign w_user_wr = wr_en & ~w_busy & addr_in_range(32'(wr_addr), DEPTH);

  // The clear engine owns the write port for the whole sweep.
  assign w_we    = w_busy | w_user_wr;
  assign w_waddr = w_busy ? r_cnt  : wr_addr;
  assign w_wdata = w_busy ? r_fill : wr_data;

  assign clr_busy = w_busy;
  assign wr_ready = ~w_busy;
  assign clr_done = r_done;

  // Clear sequencer: state, sweep counter, latched fill colour and done pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= (CLEAR_ON_RESET != 0) ? FB_ST_CLEAR : FB_ST_IDLE;
      r_cnt   <= '0;
      r_fill  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        FB_ST_IDLE: begin
          if (clr_start) begin
            r_state <= FB_ST_CLEAR;
            r_fill  <= clr_value;
            r_cnt   <= '0;
          end
        end
        FB_ST_CLEAR: begin
          if (w_last) begin
            r_state <= FB_ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + ADDR_WIDTH'(1);
          end
        end
        default: r_state <= FB_ST_IDLE;
      endcase
    end
  end

  frame_buffer_ram_dp_ram_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_core (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (rd_en),
    .i_raddr (rd_addr),
    .o_rdata (w_rd_q)
  );

  // First read-valid stage, aligned with the RAM's registered data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rd_v1 <= 1'b0;
    else          r_rd_v1 <= rd_en;
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] r_rd_d2;
      logic                  r_rd_v2;

      // Extra output stage; captures only real reads so rd_data holds otherwise
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_rd_d2 <= '0;
          r_rd_v2 <= 1'b0;
        end else begin
          r_rd_v2 <= r_rd_v1;
          if (r_rd_v1) r_rd_d2 <= w_rd_q;
        end
      end

      assign rd_data  = r_rd_d2;
      assign rd_valid = r_rd_v2;
    end else begin : g_no_out_reg
      logic r_rd_seen;

      // The RAM register has no reset, so mask it to zero until a read lands
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rd_seen <= 1'b0;
        else if (rd_en) r_rd_seen <= 1'b1;
      end

      assign rd_data  = r_rd_seen ? w_rd_q : '0;
      assign rd_valid = r_rd_v1;
    end
  endgenerate

endmodule

// File: tb/tb_frame_buffer_ram.sv
// Bench for frame_buffer_ram: u_a (OUT_REG=0, CLEAR_ON_RESET=1) and
// u_b (OUT_REG=1, CLEAR_ON_RESET=0), each with its own read scoreboard.
module tb_frame_buffer_ram;

  localparam int AW    = 4;
  localparam int DW    = 3;
  localparam int DEPTH = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_tot  = 0;

  logic          a_reset_n, a_wr_en, a_wr_ready, a_rd_en, a_rd_valid, a_clr_start, a_clr_busy, a_clr_done;
  logic [AW-1:0] a_wr_addr, a_rd_addr;
  logic [DW-1:0] a_wr_data, a_rd_data, a_clr_value;
  logic          b_reset_n, b_wr_en, b_wr_ready, b_rd_en, b_rd_valid, b_clr_start, b_clr_busy, b_clr_done;
  logic [AW-1:0] b_wr_addr, b_rd_addr;
  logic [DW-1:0] b_wr_data, b_rd_data, b_clr_value;

  frame_buffer_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .reset_n(a_reset_n), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .wr_ready(a_wr_ready), .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .clr_start(a_clr_start), .clr_value(a_clr_value), .clr_busy(a_clr_busy), .clr_done(a_clr_done));

  frame_buffer_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .OUT_REG(1), .CLEAR_ON_RESET(0)) u_b (
    .clk(clk), .reset_n(b_reset_n), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .wr_ready(b_wr_ready), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .clr_start(b_clr_start), .clr_value(b_clr_value), .clr_busy(b_clr_busy), .clr_done(b_clr_done));

  typedef struct {
    logic [DW-1:0] data;
    bit            chk;
    int            due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  typedef struct {
    bit            we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    bit            re;
    logic [AW-1:0] ra;
    bit            chkd;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl[9];

  logic [DW-1:0] bm [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for u_a: read latency 1
  always @(negedge clk) begin
    exp_t e;
    if (a_reset_n === 1'b1) begin
      if (a_rd_valid === 1'b1) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_valid", 1, 0);
        end else begin
          e = qa.pop_front();
          chk("a_rd_latency", cyc, e.due);
          if (e.chk) chk("a_rd_data", a_rd_data, e.data);
        end
      end else if (qa.size() > 0 && qa[0].due <= cyc) begin
        e = qa.pop_front();
        chk("a_missing_valid", 0, 1);
      end
    end
  end

  // Scoreboard for u_b: read latency 2
  always @(negedge clk) begin
    exp_t e;
    if (b_reset_n === 1'b1) begin
      if (b_rd_valid === 1'b1) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_valid", 1, 0);
        end else begin
          e = qb.pop_front();
          chk("b_rd_latency", cyc, e.due);
          if (e.chk) chk("b_rd_data", b_rd_data, e.data);
        end
      end else if (qb.size() > 0 && qb[0].due <= cyc) begin
        e = qb.pop_front();
        chk("b_missing_valid", 0, 1);
      end
    end
  end

  task automatic a_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input bit chkd);
    a_rd_en   = 1'b1;
    a_rd_addr = addr;
    qa.push_back('{data: exp, chk: chkd, due: cyc + 1});
  endtask

  task automatic b_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input bit chkd);
    b_rd_en   = 1'b1;
    b_rd_addr = addr;
    qb.push_back('{data: exp, chk: chkd, due: cyc + 2});
  endtask

  task automatic a_read_all(input logic [DW-1:0] exp);
    for (int i = 0; i < DEPTH; i++) begin
      a_read(AW'(i), exp, 1'b1);
      tick();
    end
    a_rd_en = 1'b0;
    repeat (3) tick();
  endtask

  task automatic a_count(input int n, output int busy_n, output int done_n);
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      busy_n += int'(a_clr_busy);
      done_n += int'(a_clr_done);
    end
  endtask

  initial begin #200000; $display("FAIL watchdog: simulation time limit reached"); $fatal(1); end

  initial begin
    int busy_n, done_n, bbusy_n;
    bit found;

    tbl[0] = '{we: 1, wa: 4'd5,  wd: 3'd5, re: 0, ra: 4'd0,  chkd: 0, exp: 3'd0};
    tbl[1] = '{we: 0, wa: 4'd0,  wd: 3'd0, re: 1, ra: 4'd5,  chkd: 1, exp: 3'd5};
    tbl[2] = '{we: 1, wa: 4'd7,  wd: 3'd2, re: 0, ra: 4'd0,  chkd: 0, exp: 3'd0};
    tbl[3] = '{we: 1, wa: 4'd7,  wd: 3'd7, re: 1, ra: 4'd7,  chkd: 1, exp: 3'd2};
    tbl[4] = '{we: 0, wa: 4'd0,  wd: 3'd0, re: 1, ra: 4'd7,  chkd: 1, exp: 3'd7};
    tbl[5] = '{we: 1, wa: 4'd0,  wd: 3'd3, re: 1, ra: 4'd5,  chkd: 1, exp: 3'd5};
    tbl[6] = '{we: 1, wa: 4'd11, wd: 3'd6, re: 1, ra: 4'd0,  chkd: 1, exp: 3'd3};
    tbl[7] = '{we: 0, wa: 4'd0,  wd: 3'd0, re: 1, ra: 4'd11, chkd: 1, exp: 3'd6};
    tbl[8] = '{we: 0, wa: 4'd0,  wd: 3'd0, re: 1, ra: 4'd13, chkd: 0, exp: 3'd0};

    a_reset_n = 0; a_wr_en = 0; a_wr_addr = '0; a_wr_data = '0; a_rd_en = 0; a_rd_addr = '0;
    a_clr_start = 0; a_clr_value = '0;
    b_reset_n = 0; b_wr_en = 0; b_wr_addr = '0; b_wr_data = '0; b_rd_en = 0; b_rd_addr = '0;
    b_clr_start = 0; b_clr_value = '0;
    repeat (3) tick();

    chk("a_rst_busy", a_clr_busy, 1);
    chk("a_rst_wr_ready", a_wr_ready, 0);
    chk("a_rst_rd_valid", a_rd_valid, 0);
    chk("a_rst_rd_data", a_rd_data, 0);
    chk("a_rst_done", a_clr_done, 0);
    chk("b_rst_busy", b_clr_busy, 0);
    chk("b_rst_wr_ready", b_wr_ready, 1);
    chk("b_rst_rd_valid", b_rd_valid, 0);
    chk("b_rst_rd_data", b_rd_data, 0);

    // Auto-clear after reset release on u_a; u_b stays idle
    a_reset_n = 1;
    b_reset_n = 1;
    bbusy_n = 0;
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      busy_n  += int'(a_clr_busy);
      done_n  += int'(a_clr_done);
      bbusy_n += int'(b_clr_busy);
    end
    chk("a_auto_clear_busy_cycles", busy_n, DEPTH);
    chk("a_auto_clear_done_pulses", done_n, 1);
    chk("b_no_auto_clear", bbusy_n, 0);
    tick();
    a_read_all(3'd0);

    // Table: write/read, read-first collision, boundary address, out-of-range read
    for (int i = 0; i < 9; i++) begin
      a_wr_en   = tbl[i].we;
      a_wr_addr = tbl[i].wa;
      a_wr_data = tbl[i].wd;
      a_rd_en   = 1'b0;
      if (tbl[i].re) a_read(tbl[i].ra, tbl[i].exp, tbl[i].chkd);
      tick();
    end
    a_wr_en = 0;
    a_rd_en = 0;
    repeat (3) tick();
    chk("a_rd_valid_drops", a_rd_valid, 0);
    chk("a_rd_data_holds", a_rd_data, 0);

    // Clear to 2 with blocked user writes and an ignored restart request
    a_clr_start = 1; a_clr_value = 3'd2;
    tick();
    a_wr_en = 1; a_wr_addr = 4'd3; a_wr_data = 3'd7;
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < 20; i++) begin
      a_clr_start = (i == 4);
      a_clr_value = (i == 4) ? 3'd5 : 3'd2;
      if (i == 8) a_wr_en = 0;
      @(negedge clk);
      busy_n += int'(a_clr_busy);
      done_n += int'(a_clr_done);
      if (i < DEPTH) chk("a_wr_ready_in_clear", a_wr_ready, 0);
      if (i == DEPTH) chk("a_done_after_last", a_clr_done, 1);
      tick();
    end
    chk("a_clear_busy_cycles", busy_n, DEPTH);
    chk("a_clear_done_pulses", done_n, 1);
    a_read_all(3'd2);

    // Out-of-range write must not alias onto a real address
    a_wr_en = 1; a_wr_addr = 4'd13; a_wr_data = 3'd5;
    tick();
    a_wr_en = 0;
    a_read(4'd1, 3'd2, 1'b1);
    tick();
    a_read(4'd13, 3'd0, 1'b0);
    tick();
    a_rd_en = 0;
    repeat (3) tick();

    // clr_start on the done cycle starts a new clear
    a_clr_start = 1; a_clr_value = 3'd3;
    tick();
    a_clr_start = 0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_clr_done === 1'b1) begin
        found = 1;
        break;
      end
    end
    chk("a_done_seen", found, 1);
    a_clr_start = 1; a_clr_value = 3'd4;
    @(posedge clk);
    #1;
    a_clr_start = 0;
    a_count(20, busy_n, done_n);
    chk("a_back_to_back_busy", busy_n, DEPTH);
    chk("a_back_to_back_done", done_n, 1);
    tick();
    a_read_all(3'd4);

    // u_b: fill with a pattern and read back at latency 2
    for (int i = 0; i < DEPTH; i++) begin
      bm[i] = DW'(i + 1);
      b_wr_en = 1; b_wr_addr = AW'(i); b_wr_data = bm[i];
      tick();
    end
    b_wr_en = 0;
    for (int i = 0; i < DEPTH; i++) begin
      b_read(AW'(i), bm[i], 1'b1);
      tick();
    end
    b_rd_en = 0;
    repeat (4) tick();
    chk("b_rd_valid_drops", b_rd_valid, 0);
    chk("b_rd_data_holds", b_rd_data, bm[DEPTH-1]);

    // u_b: reset in the middle of a clear, counter at 6
    b_clr_start = 1; b_clr_value = 3'd6;
    b_read(4'd11, bm[11], 1'b1);
    tick();
    b_clr_start = 0;
    for (int k = 1; k <= 6; k++) begin
      b_read(4'd11, bm[11], 1'b1);
      tick();
    end
    chk("b_busy_before_abort", b_clr_busy, 1);
    chk("b_valid_before_abort", b_rd_valid, 1);
    b_reset_n = 0;
    b_rd_en = 0;
    qb.delete();
    #1;
    chk("b_abort_busy", b_clr_busy, 0);
    chk("b_abort_wr_ready", b_wr_ready, 1);
    chk("b_abort_rd_valid", b_rd_valid, 0);
    chk("b_abort_rd_data", b_rd_data, 0);
    chk("b_abort_done", b_clr_done, 0);
    repeat (2) tick();
    b_reset_n = 1;
    bbusy_n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bbusy_n += int'(b_clr_busy);
    end
    chk("b_stays_idle_after_abort", bbusy_n, 0);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      b_read(AW'(i), (i < 6) ? 3'd6 : bm[i], 1'b1);
      tick();
    end
    b_rd_en = 0;

    repeat (10) tick();
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
